// File: rtl/led_scheduler_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | led_scheduler_if : push-button inputs and LED/step outputs bundle     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface led_scheduler_if;
  logic       btn_next;
  logic       btn_prev;
  logic       btn_mode;
  logic [2:0] ledout;
  logic [1:0] step;
  logic       auto_active;
  logic       tick;

  modport master (
    output btn_next, btn_prev, btn_mode,
    input  ledout, step, auto_active, tick
  );

  modport slave (
    input  btn_next, btn_prev, btn_mode,
    output ledout, step, auto_active, tick
  );
endinterface
`default_nettype wire

// File: rtl/led_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | led_scheduler : 4-step LED sequencer, manual step or timed auto run;  |
// | auto mode exists only when LED_SCHEDULER_AUTO_EN is defined. Rev 1.0  |
// +----------------------------------------------------------------------+
module led_scheduler #(
  parameter int unsigned TICK_DIV = 50000000
) (
  input wire            clk,
  input wire            rst,
  led_scheduler_if.slave bus
);

  function automatic logic [2:0] f_decode(input logic [1:0] s);
    case (s)
      2'd0:    f_decode = 3'b001;
      2'd1:    f_decode = 3'b010;
      2'd2:    f_decode = 3'b011;
      default: f_decode = 3'b100;
    endcase
  endfunction

  logic       r_prev_next;
  logic       r_prev_prev;
  logic [1:0] r_step;
  logic [2:0] r_led;
  logic       w_next_edge;
  logic       w_prev_edge;
  logic [1:0] w_manual_step;
  logic [1:0] w_step_nxt;

  assign w_next_edge = bus.btn_next & ~r_prev_next;
  assign w_prev_edge = bus.btn_prev & ~r_prev_prev;

  // Simultaneous next/prev edges cancel out.
  always_comb begin
    w_manual_step = r_step;
    case ({w_next_edge, w_prev_edge})
      2'b10:   w_manual_step = r_step + 2'd1;
      2'b01:   w_manual_step = r_step - 2'd1;
      default: w_manual_step = r_step;
    endcase
  end

  assign bus.step   = r_step;
  assign bus.ledout = r_led;

`ifdef LED_SCHEDULER_AUTO_EN
  localparam logic [1:0]  c_ST_MANUAL     = 2'd0;
  localparam logic [1:0]  c_ST_AUTO_RUN   = 2'd1;
  localparam logic [1:0]  c_ST_AUTO_PAUSE = 2'd2;
  localparam logic [31:0] c_TICK_LAST     = 32'(TICK_DIV - 1);

  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;
  logic        r_prev_mode;
  logic        w_mode_edge;
  logic [31:0] r_cnt;
  logic [31:0] w_cnt_nxt;
  logic        r_tick;
  logic        w_tick_nxt;
  logic        r_auto;

  assign w_mode_edge = bus.btn_mode & ~r_prev_mode;

  // Prev registers reset high so a button held through reset is not an edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= c_ST_MANUAL;
      r_prev_next <= 1'b1;
      r_prev_prev <= 1'b1;
      r_prev_mode <= 1'b1;
      r_step      <= 2'd0;
      r_led       <= 3'b001;
      r_cnt       <= '0;
      r_tick      <= 1'b0;
      r_auto      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_prev_next <= bus.btn_next;
      r_prev_prev <= bus.btn_prev;
      r_prev_mode <= bus.btn_mode;
      r_step      <= w_step_nxt;
      r_led       <= f_decode(w_step_nxt);
      r_cnt       <= w_cnt_nxt;
      r_tick      <= w_tick_nxt;
      r_auto      <= (w_state_nxt != c_ST_MANUAL);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_MANUAL:
        if (w_mode_edge) w_state_nxt = c_ST_AUTO_RUN;
      c_ST_AUTO_RUN:
        if (w_mode_edge)      w_state_nxt = c_ST_MANUAL;
        else if (w_next_edge) w_state_nxt = c_ST_AUTO_PAUSE;
      c_ST_AUTO_PAUSE:
        if (w_mode_edge)      w_state_nxt = c_ST_MANUAL;
        else if (w_next_edge) w_state_nxt = c_ST_AUTO_RUN;
      default:
        w_state_nxt = c_ST_MANUAL;
    endcase
  end

  // Mode edge outranks pause/resume and terminal count.
  always_comb begin
    w_step_nxt = r_step;
    w_cnt_nxt  = r_cnt;
    w_tick_nxt = 1'b0;
    case (r_state)
      c_ST_MANUAL: begin
        w_cnt_nxt = '0;
        if (!w_mode_edge) w_step_nxt = w_manual_step;
      end
      c_ST_AUTO_RUN: begin
        if (w_mode_edge) begin
          w_cnt_nxt = '0;
        end else if (w_next_edge) begin
          w_cnt_nxt = r_cnt;
        end else if (r_cnt == c_TICK_LAST) begin
          w_cnt_nxt  = '0;
          w_step_nxt = r_step + 2'd1;
          w_tick_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 32'd1;
        end
      end
      c_ST_AUTO_PAUSE: begin
        if (w_mode_edge) w_cnt_nxt = '0;
      end
      default: w_cnt_nxt = '0;
    endcase
  end

  assign bus.auto_active = r_auto;
  assign bus.tick        = r_tick;
`else
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_prev_next <= 1'b1;
      r_prev_prev <= 1'b1;
      r_step      <= 2'd0;
      r_led       <= 3'b001;
    end else begin
      r_prev_next <= bus.btn_next;
      r_prev_prev <= bus.btn_prev;
      r_step      <= w_step_nxt;
      r_led       <= f_decode(w_step_nxt);
    end
  end

  assign w_step_nxt      = w_manual_step;
  assign bus.auto_active = 1'b0;
  assign bus.tick        = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_led_scheduler.sv
`default_nettype none
// tb_led_scheduler : random + directed button stimulus, reference model feeds
// an expected-output queue that an independent monitor drains every cycle.
module tb_led_scheduler;
  localparam int TDIV = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  led_scheduler_if bus ();

  led_scheduler #(.TICK_DIV(TDIV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference model: step as an integer, auto mode as run/paused flags,
  // counter as number of running cycles since the last advance.
  int   m_step = 0;
  int   m_cnt  = 0;
  bit   m_auto = 0;
  bit   m_paused = 0;
  bit   m_tick = 0;
  bit   m_pn = 1, m_pp = 1, m_pm = 1;
  logic [2:0] led_tab [4] = '{3'b001, 3'b010, 3'b011, 3'b100};

  logic [6:0] exp_q [$];
  int total = 0;
  int bad   = 0;
  bit done  = 0;

  task automatic model_manual(input bit en, input bit ep);
    if (en && !ep)      m_step = (m_step + 1) % 4;
    else if (ep && !en) m_step = (m_step + 3) % 4;
  endtask

  task automatic model(input bit n, input bit p, input bit m, input bit r);
    bit en, ep;
    if (!r) begin
      m_step = 0; m_cnt = 0; m_auto = 0; m_paused = 0; m_tick = 0;
      m_pn = 1; m_pp = 1; m_pm = 1;
    end else begin
      en = n && !m_pn;
      ep = p && !m_pp;
      m_tick = 0;
`ifdef LED_SCHEDULER_AUTO_EN
      begin
        bit em;
        em = m && !m_pm;
        if (m_auto) begin
          if (em) begin
            m_auto = 0; m_paused = 0; m_cnt = 0;
          end else if (en) begin
            m_paused = !m_paused;
          end else if (!m_paused) begin
            m_cnt++;
            if (m_cnt == TDIV) begin
              m_cnt = 0; m_step = (m_step + 1) % 4; m_tick = 1;
            end
          end
        end else if (em) begin
          m_auto = 1; m_paused = 0; m_cnt = 0;
        end else begin
          model_manual(en, ep);
        end
      end
`else
      model_manual(en, ep);
`endif
      m_pn = n; m_pp = p; m_pm = m;
    end
  endtask

  task automatic drive(input bit n, input bit p, input bit m, input bit r);
    logic [1:0] s;
    @(negedge clk);
    bus.btn_next = n;
    bus.btn_prev = p;
    bus.btn_mode = m;
    rst          = r;
    model(n, p, m, r);
    s = m_step[1:0];
    exp_q.push_back({s, led_tab[m_step], m_auto, m_tick});
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) drive(0, 0, 0, 1);
  endtask

  task automatic pulse(input bit n, input bit p, input bit m);
    drive(n, p, m, 1);
    drive(0, 0, 0, 1);
  endtask

  initial begin
    bus.btn_next = 0;
    bus.btn_prev = 0;
    bus.btn_mode = 0;
    fork
      begin : driver
        bit n, p, m;
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        idle(2);
        for (int i = 0; i < 4; i++) pulse(1, 0, 0);
        pulse(0, 1, 0);
        pulse(1, 1, 0);
        for (int i = 0; i < 3; i++) pulse(0, 0, 1);
        idle(3);
        // Walk to step 1, enter auto, pause/resume, then reset with next held.
        while (m_step != 1) pulse(1, 0, 0);
        pulse(0, 0, 1);
        idle(14);
        pulse(1, 0, 0);
        idle(20);
        pulse(1, 0, 0);
        idle(4);
        drive(1, 0, 0, 1);
        drive(1, 0, 0, 0);
        drive(1, 0, 0, 0);
        drive(1, 0, 0, 1);
        drive(1, 0, 0, 1);
        drive(0, 0, 0, 1);
        pulse(0, 0, 1);
        idle(6);
        pulse(0, 1, 1);
        idle(3);
        n = 0; p = 0; m = 0;
        for (int i = 0; i < 600; i++) begin
          if ($urandom_range(3) == 0) n = !n;
          if ($urandom_range(3) == 0) p = !p;
          if ($urandom_range(7) == 0) m = !m;
          drive(n, p, m, $urandom_range(39) != 0);
        end
        idle(2);
        done = 1;
      end
      begin : monitor
        logic [6:0] exp, act;
        int cyc;
        cyc = 0;
        while (!done || exp_q.size() != 0) begin
          @(posedge clk);
          #1;
          cyc++;
          if (cyc > 50000) begin
            total++;
            bad++;
            $display("FAIL timeout: queue=%0d required empty", exp_q.size());
            break;
          end
          if (exp_q.size() != 0) begin
            exp = exp_q.pop_front();
            act = {bus.step, bus.ledout, bus.auto_active, bus.tick};
            total++;
            if (act !== exp) begin
              bad++;
              $display("FAIL outputs cyc=%0d: step=%0d led=%b auto=%b tick=%b, required step=%0d led=%b auto=%b tick=%b",
                       cyc, act[6:5], act[4:2], act[1], act[0],
                       exp[6:5], exp[4:2], exp[1], exp[0]);
            end
          end
        end
      end
    join
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/led_scheduler.md
LED_SCHEDULER -- requirements
Module: led_scheduler

Interface
REQ-001 Parameter TICK_DIV, default 50000000, clock cycles per automatic step advance; legal range 2 to 2^32-1.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous, active-low reset; sampled on clk rising edge.
REQ-004 btn_next  input  1  level from push button; rising edge requests step+1 (manual) or run/pause toggle (auto).
REQ-005 btn_prev  input  1  level from push button; rising edge requests step-1 (manual only).
REQ-006 btn_mode  input  1  level from push button; rising edge toggles manual/auto.
REQ-007 ledout  output  3  registered LED pattern for current step.
REQ-008 step  output  2  registered current step index.
REQ-009 auto_active  output  1  registered; 1 in AUTO_RUN or AUTO_PAUSE.
REQ-010 tick  output  1  registered one-cycle pulse coincident with each automatic step advance.

Function
REQ-011 Each button SHALL have a previous-value register; edge = btn & ~prev, evaluated on the current-cycle input, no debounce filtering.
REQ-012 Step changes SHALL be visible on step and ledout exactly one clock after the edge where the button is first sampled high.
REQ-013 ledout SHALL always be the decode of step: 0->001, 1->010, 2->011, 3->100; no other ledout value is legal.
REQ-014 Step arithmetic SHALL be 2-bit modulo: 3+1->0, 0-1->3.
REQ-015 FSM states SHALL be MANUAL, AUTO_RUN, AUTO_PAUSE.
REQ-016 MANUAL: next edge alone -> step+1; prev edge alone -> step-1; next and prev edges in the same cycle -> no change.
REQ-017 MANUAL + mode edge -> AUTO_RUN, tick counter cleared to 0; next/prev edges in that cycle ignored.
REQ-018 AUTO_RUN: tick counter increments each cycle; at TICK_DIV-1 it returns to 0, step+1, tick=1 for one cycle.
REQ-019 AUTO_RUN + next edge -> AUTO_PAUSE; counter holds value; no step advance in that cycle even at terminal count.
REQ-020 AUTO_PAUSE + next edge -> AUTO_RUN; counter resumes from held value.
REQ-021 AUTO_RUN or AUTO_PAUSE + mode edge -> MANUAL; step retained; counter cleared; mode edge has priority over next edge and terminal count in the same cycle.
REQ-022 btn_prev SHALL be ignored in AUTO_RUN and AUTO_PAUSE.
REQ-023 tick SHALL be 0 in every state except the cycle after an automatic advance.

Reset
REQ-024 With rst=0 at a rising edge: state=MANUAL, step=0, ledout=001, auto_active=0, tick=0, counter=0.
REQ-025 All prev registers SHALL reset to 1 so a button held through reset produces no edge on release of reset.
REQ-026 Reset SHALL override all button edges and terminal count in the same cycle, including mid-run in AUTO_RUN.

Configuration
REQ-027 Macro LED_SCHEDULER_AUTO_EN: defined -> full three-state behaviour above.
REQ-028 LED_SCHEDULER_AUTO_EN undefined -> no tick counter, FSM fixed at MANUAL, btn_mode ignored, auto_active and tick tied 0, TICK_DIV unused; REQ-016 behaviour unchanged.

Verification (TICK_DIV=4)
REQ-029 Reset released, 4 btn_next pulses -> step 1,2,3,0; ledout 010,011,100,001, each one clock after the pulse.
REQ-030 From step 0, btn_prev pulse -> step 3, ledout 100; btn_next and btn_prev rising in same cycle -> step unchanged.
REQ-031 mode pulse from step 1 -> auto_active=1; step 2,3,0 at 4-cycle intervals, each with a one-cycle tick.
REQ-032 AUTO_RUN, next pulse after 2 counted cycles -> no advance for 20 cycles; next pulse again -> advance 2 cycles later.
REQ-033 rst=0 asserted mid AUTO_RUN with btn_next held high -> step=0, ledout=001, auto_active=0; releasing rst with button still high -> no step change.
REQ-034 Build without LED_SCHEDULER_AUTO_EN, 3 mode pulses -> auto_active stays 0, tick stays 0, step unchanged.
